ext_r_responder_ipa: RTL and testbench

// - AXI4 read-channel responder: takes AR requests, generates one memory read per beat, returns R beats.
// - Sits behind the AR buffer at the external-memory end, replacing a full AXI slave for SRAM-style memories.
// - One burst in flight; 2-entry R skid FIFO absorbs master_r_ready_i backpressure.

---
 rtl/ext_r_responder_ipa.sv | 176 +++++++++++++++++
 tb/tb_ext_r_responder_ipa.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ext_r_responder_ipa.sv
// AXI4 read responder for SRAM-style memories: one burst in flight, credit-limited memory reads, 2-entry R FIFO.
// Optional EXT_R_RESP_4K_CHECK_EN: INCR bursts crossing a 4 KB boundary return SLVERR on every beat.
module ext_r_responder_ipa #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int USER_WIDTH = 6,
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ar_valid_i,
  input  logic [ADDR_WIDTH-1:0] ar_addr_i,
  input  logic [7:0]            ar_len_i,
  input  logic [2:0]            ar_size_i,
  input  logic [1:0]            ar_burst_i,
  input  logic [ID_WIDTH-1:0]   ar_id_i,
  input  logic [USER_WIDTH-1:0] ar_user_i,
  output logic                  ar_ready_o,
  output logic                  r_valid_o,
  output logic [DATA_WIDTH-1:0] r_data_o,
  output logic [1:0]            r_resp_o,
  output logic                  r_last_o,
  output logic [ID_WIDTH-1:0]   r_id_o,
  output logic [USER_WIDTH-1:0] r_user_o,
  input  logic                  r_ready_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_WIDTH/8));

  typedef enum logic {S_IDLE, S_BURST} state_t;
  state_t r_state, w_state_nxt;

  logic                  r_ar_ready;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err;
  logic [ID_WIDTH-1:0]   r_id;
  logic [USER_WIDTH-1:0] r_user;
  logic [8:0]            r_req_left;
  logic [7:0]            r_beat_idx;
  logic [1:0]            r_outst;
  logic [DATA_WIDTH-1:0] r_fdata [2];
  logic [1:0]            r_fresp [2];
  logic [1:0]            r_flast;
  logic                  r_wp, r_rp;
  logic [1:0]            r_cnt;

  logic                  w_ar_hs, w_wrap_len_ok, w_4k_err, w_ar_err;
  logic [ADDR_WIDTH-1:0] w_ar_aligned, w_step, w_incr, w_wrap_mask, w_next_addr;
  logic                  w_credit, w_gnt, w_rd_push, w_err_push, w_push, w_pop;

  assign w_ar_hs       = ar_valid_i & r_ar_ready;
  assign w_ar_aligned  = ar_addr_i & ~((ADDR_WIDTH'(1) << ar_size_i) - ADDR_WIDTH'(1));
  assign w_wrap_len_ok = (ar_len_i == 8'd1) | (ar_len_i == 8'd3) | (ar_len_i == 8'd7) | (ar_len_i == 8'd15);

`ifdef EXT_R_RESP_4K_CHECK_EN
  // One extra bit so a burst running off the top of the address space also counts as a crossing.
  logic [ADDR_WIDTH:0] w_ar_end;
  assign w_ar_end = {1'b0, w_ar_aligned}
                  + (((ADDR_WIDTH+1)'(ar_len_i) + (ADDR_WIDTH+1)'(1)) << ar_size_i) - (ADDR_WIDTH+1)'(1);
  assign w_4k_err = (ar_burst_i == 2'b01) && (w_ar_end[ADDR_WIDTH:12] != {1'b0, w_ar_aligned[ADDR_WIDTH-1:12]});
`else
  assign w_4k_err = 1'b0;
`endif

  assign w_ar_err = (ar_burst_i == 2'b11) | (ar_size_i > MAX_SIZE)
                  | ((ar_burst_i == 2'b10) & ~w_wrap_len_ok) | w_4k_err;

  assign w_step      = ADDR_WIDTH'(1) << r_size;
  assign w_incr      = r_addr + w_step;
  assign w_wrap_mask = ((ADDR_WIDTH'(r_len) + ADDR_WIDTH'(1)) << r_size) - ADDR_WIDTH'(1);

  always_comb begin
    w_next_addr = w_incr;
    case (r_burst)
      2'b00:   w_next_addr = r_addr;
      2'b10:   w_next_addr = (r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
      default: w_next_addr = w_incr;
    endcase
  end

  // Every slot either in flight or in the FIFO is a reserved FIFO entry, so the FIFO can never overflow.
  assign w_credit   = (r_state == S_BURST) && (r_req_left != 9'd0)
                    && ((3'(r_outst) + 3'(r_cnt)) < 3'd2);
  assign mem_req_o  = w_credit & ~r_err;
  assign mem_addr_o = r_addr;
  assign w_gnt      = mem_req_o & mem_gnt_i;
  assign w_err_push = w_credit & r_err;
  assign w_rd_push  = mem_rvalid_i & (r_outst != 2'd0);
  assign w_push     = w_rd_push | w_err_push;
  assign w_pop      = r_valid_o & r_ready_i;

  assign ar_ready_o = r_ar_ready;
  assign r_valid_o  = (r_cnt != 2'd0);
  assign r_data_o   = r_fdata[r_rp];
  assign r_resp_o   = r_fresp[r_rp];
  assign r_last_o   = r_flast[r_rp];
  assign r_id_o     = r_id;
  assign r_user_o   = r_user;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_ar_hs) w_state_nxt = S_BURST;
      S_BURST: if (w_pop && r_last_o) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state    <= S_IDLE;
      r_ar_ready <= 1'b0;
      r_addr     <= '0;
      r_len      <= '0;
      r_size     <= '0;
      r_burst    <= '0;
      r_err      <= 1'b0;
      r_id       <= '0;
      r_user     <= '0;
      r_req_left <= '0;
      r_beat_idx <= '0;
      r_outst    <= '0;
      r_flast    <= '0;
      r_wp       <= 1'b0;
      r_rp       <= 1'b0;
      r_cnt      <= '0;
      for (int i = 0; i < 2; i++) begin
        r_fdata[i] <= '0;
        r_fresp[i] <= '0;
      end
    end else begin
      r_state    <= w_state_nxt;
      r_ar_ready <= (w_state_nxt == S_IDLE);
      if (w_ar_hs) begin
        r_addr     <= w_ar_aligned;
        r_len      <= ar_len_i;
        r_size     <= ar_size_i;
        r_burst    <= ar_burst_i;
        r_err      <= w_ar_err;
        r_id       <= ar_id_i;
        r_user     <= ar_user_i;
        r_req_left <= {1'b0, ar_len_i} + 9'd1;
        r_beat_idx <= '0;
      end else begin
        if (w_gnt || w_err_push) r_req_left <= r_req_left - 9'd1;
        if (w_gnt)               r_addr     <= w_next_addr;
        if (w_push)              r_beat_idx <= r_beat_idx + 8'd1;
      end
      case ({w_gnt, w_rd_push})
        2'b10:   r_outst <= r_outst + 2'd1;
        2'b01:   r_outst <= r_outst - 2'd1;
        default: r_outst <= r_outst;
      endcase
      // Push into the head slot while it is being popped is safe: the pop moves the read pointer off it.
      if (w_push) begin
        r_fdata[r_wp] <= w_err_push ? '0 : mem_rdata_i;
        r_fresp[r_wp] <= r_err ? 2'b10 : 2'b00;
        r_flast[r_wp] <= (r_beat_idx == r_len);
        r_wp          <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
    end
  end

  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    !(w_push && !w_pop && r_cnt == 2'd2));

endmodule

// File: tb/tb_ext_r_responder_ipa.sv
// Directed bench for ext_r_responder_ipa: vector table of bursts plus latency, backpressure and reset sequences.
module tb_ext_r_responder_ipa;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ar_valid = 1'b0;
  logic [31:0] ar_addr = '0;
  logic [7:0]  ar_len = '0;
  logic [2:0]  ar_size = '0;
  logic [1:0]  ar_burst = '0;
  logic [3:0]  ar_id = '0;
  logic [5:0]  ar_user = '0;
  logic        ar_ready;
  logic        r_valid, r_last, r_ready = 1'b1;
  logic [63:0] r_data;
  logic [1:0]  r_resp;
  logic [3:0]  r_id;
  logic [5:0]  r_user;
  logic        mem_req, mem_gnt = 1'b1, mem_rvalid = 1'b0;
  logic [31:0] mem_addr;
  logic [63:0] mem_rdata = '0;

  always #5 clk = ~clk;

  ext_r_responder_ipa dut (
    .clk_i(clk), .rst_i(rst),
    .ar_valid_i(ar_valid), .ar_addr_i(ar_addr), .ar_len_i(ar_len), .ar_size_i(ar_size),
    .ar_burst_i(ar_burst), .ar_id_i(ar_id), .ar_user_i(ar_user), .ar_ready_o(ar_ready),
    .r_valid_o(r_valid), .r_data_o(r_data), .r_resp_o(r_resp), .r_last_o(r_last),
    .r_id_o(r_id), .r_user_o(r_user), .r_ready_i(r_ready),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
  );

  // Memory answers one cycle after grant with data tagged by its address; it ignores rst on purpose.
  always @(posedge clk) begin
    mem_rvalid <= mem_req & mem_gnt;
    mem_rdata  <= {mem_addr, ~mem_addr};
  end

  logic [63:0] qd[$];
  logic [1:0]  qr[$];
  logic        ql[$];
  logic [3:0]  qid[$];
  logic [5:0]  qu[$];
  logic [31:0] qa[$];

  always @(negedge clk) begin
    if (r_valid && r_ready) begin
      qd.push_back(r_data); qr.push_back(r_resp); ql.push_back(r_last);
      qid.push_back(r_id); qu.push_back(r_user);
    end
    if (mem_req && mem_gnt) qa.push_back(mem_addr);
  end

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic clear_q();
    qd.delete(); qr.delete(); ql.delete(); qid.delete(); qu.delete(); qa.delete();
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                         input logic [1:0] b, input logic [3:0] id, input logic [5:0] u);
    int t = 0;
    while (!ar_ready && t < 50) begin @(posedge clk); #1; t++; end
    chk("ar_ready_wait", 64'(ar_ready), 64'd1);
    ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_id = id; ar_user = u; ar_valid = 1'b1;
    @(posedge clk); #1;
    ar_valid = 1'b0;
  endtask

  task automatic wait_beats(input string nm, input int n);
    int t = 0;
    while (qd.size() < n && t < 300) begin @(posedge clk); #1; t++; end
    chk(nm, 64'(qd.size()), 64'(n));
  endtask

  typedef struct {
    logic [31:0]      addr;
    logic [7:0]       len;
    logic [2:0]       size;
    logic [1:0]       burst;
    logic [3:0]       id;
    logic [5:0]       user;
    logic             err;
    int               nreq;
    logic [3:0][31:0] ea;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] a, input logic [7:0] l, input logic [2:0] s,
                              input logic [1:0] b, input logic [3:0] id, input logic [5:0] u,
                              input logic e, input int n, input logic [3:0][31:0] ea);
    vec_t v;
    v.addr = a; v.len = l; v.size = s; v.burst = b; v.id = id; v.user = u;
    v.err = e; v.nreq = n; v.ea = ea;
    return v;
  endfunction

  vec_t vt[10];

  initial begin
    vt[0] = mk(32'h100, 8'd3, 3'd3, 2'b01, 4'd5,  6'h11, 1'b0, 4, {32'h118, 32'h110, 32'h108, 32'h100});
    vt[1] = mk(32'h038, 8'd3, 3'd3, 2'b10, 4'd2,  6'h22, 1'b0, 4, {32'h030, 32'h028, 32'h020, 32'h038});
    vt[2] = mk(32'h000, 8'd2, 3'd3, 2'b11, 4'd7,  6'h03, 1'b1, 0, '0);
`ifdef EXT_R_RESP_4K_CHECK_EN
    vt[3] = mk(32'hFF8, 8'd1, 3'd3, 2'b01, 4'd1,  6'h04, 1'b1, 0, '0);
`else
    vt[3] = mk(32'hFF8, 8'd1, 3'd3, 2'b01, 4'd1,  6'h04, 1'b0, 2, {32'h0, 32'h0, 32'h1000, 32'hFF8});
`endif
    vt[4] = mk(32'h040, 8'd2, 3'd2, 2'b00, 4'd6,  6'h05, 1'b0, 3, {32'h0, 32'h040, 32'h040, 32'h040});
    vt[5] = mk(32'h013, 8'd1, 3'd2, 2'b01, 4'd8,  6'h06, 1'b0, 2, {32'h0, 32'h0, 32'h014, 32'h010});
    vt[6] = mk(32'h080, 8'd1, 3'd4, 2'b01, 4'd9,  6'h07, 1'b1, 0, '0);
    vt[7] = mk(32'h080, 8'd2, 3'd3, 2'b10, 4'd10, 6'h08, 1'b1, 0, '0);
    vt[8] = mk(32'h200, 8'd0, 3'd3, 2'b01, 4'd11, 6'h09, 1'b0, 1, {32'h0, 32'h0, 32'h0, 32'h200});
    vt[9] = mk(32'h034, 8'd1, 3'd2, 2'b10, 4'd12, 6'h0A, 1'b0, 2, {32'h0, 32'h0, 32'h030, 32'h034});

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ar_ready", 64'(ar_ready), 64'd0);
    chk("rst_r_valid",  64'(r_valid),  64'd0);
    chk("rst_r_last",   64'(r_last),   64'd0);
    chk("rst_r_resp",   64'(r_resp),   64'd0);
    chk("rst_r_data",   r_data,        64'd0);
    chk("rst_r_id",     64'(r_id),     64'd0);
    chk("rst_r_user",   64'(r_user),   64'd0);
    chk("rst_mem_req",  64'(mem_req),  64'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    // Latency: handshake at T, mem_req at T+1, r_valid at T+3
    clear_q();
    send_ar(32'h100, 8'd0, 3'd3, 2'b01, 4'd4, 6'h02);
    chk("lat_req_t1",    64'(mem_req),  64'd1);
    chk("lat_ready_t1",  64'(ar_ready), 64'd0);
    chk("lat_rvalid_t1", 64'(r_valid),  64'd0);
    @(posedge clk); #1;
    chk("lat_rvalid_t2", 64'(r_valid),  64'd0);
    @(posedge clk); #1;
    chk("lat_rvalid_t3", 64'(r_valid),  64'd1);
    chk("lat_data",      r_data, {32'h100, ~32'h100});
    chk("lat_last",      64'(r_last),   64'd1);
    wait_beats("lat_beats", 1);
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
      clear_q();
      send_ar(vt[i].addr, vt[i].len, vt[i].size, vt[i].burst, vt[i].id, vt[i].user);
      wait_beats($sformatf("v%0d_beats", i), int'(vt[i].len) + 1);
      repeat (2) @(posedge clk);
      #1;
      chk($sformatf("v%0d_nreq", i), 64'(qa.size()), 64'(vt[i].nreq));
      for (int j = 0; j < vt[i].nreq && j < qa.size(); j++)
        chk($sformatf("v%0d_addr%0d", i, j), 64'(qa[j]), 64'(vt[i].ea[j]));
      for (int j = 0; j <= int'(vt[i].len) && j < qd.size(); j++) begin
        chk($sformatf("v%0d_data%0d", i, j), qd[j],
            vt[i].err ? 64'd0 : {vt[i].ea[j], ~vt[i].ea[j]});
        chk($sformatf("v%0d_resp%0d", i, j), 64'(qr[j]),  vt[i].err ? 64'd2 : 64'd0);
        chk($sformatf("v%0d_last%0d", i, j), 64'(ql[j]),  64'(j == int'(vt[i].len)));
        chk($sformatf("v%0d_id%0d", i, j),   64'(qid[j]), 64'(vt[i].id));
        chk($sformatf("v%0d_user%0d", i, j), 64'(qu[j]),  64'(vt[i].user));
      end
      chk($sformatf("v%0d_idle_ready", i), 64'(ar_ready), 64'd1);
    end

    // Backpressure: 10 stalled cycles allow only two grants
    clear_q();
    r_ready = 1'b0;
    send_ar(32'h0, 8'd7, 3'd3, 2'b01, 4'd3, 6'h05);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_grants",  64'(qa.size()), 64'd2);
    chk("bp_popped",  64'(qd.size()), 64'd0);
    chk("bp_r_valid", 64'(r_valid),   64'd1);
    chk("bp_head",    r_data, {32'h0, ~32'h0});
    r_ready = 1'b1;
    wait_beats("bp_beats", 8);
    repeat (2) @(posedge clk);
    #1;
    chk("bp_total_grants", 64'(qa.size()), 64'd8);
    for (int j = 0; j < 8 && j < qd.size(); j++) begin
      chk($sformatf("bp_data%0d", j), qd[j], {32'(8 * j), ~32'(8 * j)});
      chk($sformatf("bp_last%0d", j), 64'(ql[j]), 64'(j == 7));
    end

    // Reset in the middle of a 4-beat burst
    clear_q();
    send_ar(32'h100, 8'd3, 3'd3, 2'b01, 4'd5, 6'h11);
    wait_beats("mr_pre_beats", 2);
    rst = 1'b1;
    #1;
    chk("mr_ar_ready", 64'(ar_ready), 64'd0);
    chk("mr_r_valid",  64'(r_valid),  64'd0);
    chk("mr_r_last",   64'(r_last),   64'd0);
    chk("mr_r_resp",   64'(r_resp),   64'd0);
    chk("mr_r_data",   r_data,        64'd0);
    chk("mr_r_id",     64'(r_id),     64'd0);
    chk("mr_mem_req",  64'(mem_req),  64'd0);
    @(posedge clk);
    @(negedge clk); rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear_q();
    send_ar(32'h300, 8'd1, 3'd3, 2'b01, 4'd9, 6'h07);
    wait_beats("mr_post_beats", 2);
    repeat (3) @(posedge clk);
    #1;
    chk("mr_post_count", 64'(qd.size()), 64'd2);
    chk("mr_post_nreq",  64'(qa.size()), 64'd2);
    for (int j = 0; j < 2 && j < qd.size(); j++) begin
      chk($sformatf("mr_data%0d", j), qd[j], {32'h300 + 32'(8 * j), ~(32'h300 + 32'(8 * j))});
      chk($sformatf("mr_resp%0d", j), 64'(qr[j]),  64'd0);
      chk($sformatf("mr_last%0d", j), 64'(ql[j]),  64'(j == 1));
      chk($sformatf("mr_id%0d", j),   64'(qid[j]), 64'd9);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
